// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment display controller: register map,
// MODE bit positions and the hex-to-segment table.
package sseg_pkg;

  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_DP         = 3'd1;
  localparam logic [2:0] ADDR_BLANK      = 3'd2;
  localparam logic [2:0] ADDR_BLINK_MASK = 3'd3;
  localparam logic [2:0] ADDR_MODE       = 3'd4;
  localparam logic [2:0] ADDR_RAW_LO     = 3'd5;
  localparam logic [2:0] ADDR_RAW_HI     = 3'd6;
  localparam logic [2:0] ADDR_BLINK_DIV  = 3'd7;

  localparam int unsigned MODE_RAW      = 0;
  localparam int unsigned MODE_BLINK_EN = 1;
  localparam int unsigned MODE_LZS      = 2;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low g..a in [6:0]; bit7 (dp) returned inactive.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0: code = 8'hC0;
      4'h1: code = 8'hF9;
      4'h2: code = 8'hA4;
      4'h3: code = 8'hB0;
      4'h4: code = 8'h99;
      4'h5: code = 8'h92;
      4'h6: code = 8'h82;
      4'h7: code = 8'hF8;
      4'h8: code = 8'h80;
      4'h9: code = 8'h90;
      4'hA: code = 8'h88;
      4'hB: code = 8'h83;
      4'hC: code = 8'hC6;
      4'hD: code = 8'hA1;
      4'hE: code = 8'h86;
      default: code = 8'h8E;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sseg_blink_timer.sv
// Blink phase generator: a TICK_DIV-cycle prescaler feeding a 0..div tick
// counter whose wrap toggles the phase.
module sseg_blink_timer #(
  parameter int TICK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [15:0] div,
  output logic        phase
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0] tick_cnt;
  logic [15:0]   blink_cnt;
  logic          tick;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (clear) begin
      tick_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) begin
        if (blink_cnt >= div) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/sseg_ctrl.sv
// Memory-mapped eight-digit seven-segment controller: register file, read mux,
// per-digit code selection and registered active-low segment outputs.
module sseg_ctrl
  import sseg_pkg::*;
#(
  parameter int TICK_DIV      = 100000,
  parameter int BLINK_DIV_RST = 499
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic        rd,
  input  logic [2:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [7:0]  seg0,
  output logic [7:0]  seg1,
  output logic [7:0]  seg2,
  output logic [7:0]  seg3,
  output logic [7:0]  seg4,
  output logic [7:0]  seg5,
  output logic [7:0]  seg6,
  output logic [7:0]  seg7
);

  logic [31:0] data_r;
  logic [7:0]  dp_r;
  logic [7:0]  blank_r;
  logic [7:0]  mask_r;
  logic [2:0]  mode_r;
  logic [31:0] raw_lo_r;
  logic [31:0] raw_hi_r;
  logic [15:0] div_r;
  logic        phase;
  logic        timer_clear;
  logic [31:0] rd_mux;
  logic [63:0] raw_all;
  logic [7:0][7:0] next_seg;
  logic [7:0][7:0] seg_q;

  // Counters restart on any BLINK_DIV write or a 1->0 transition of BLINK_EN.
  assign timer_clear = wr && ((addr == ADDR_BLINK_DIV) ||
                              ((addr == ADDR_MODE) && mode_r[MODE_BLINK_EN] &&
                               !wr_data[MODE_BLINK_EN]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r   <= '0;
      dp_r     <= '0;
      blank_r  <= '0;
      mask_r   <= '0;
      mode_r   <= '0;
      raw_lo_r <= '1;
      raw_hi_r <= '1;
      div_r    <= 16'(BLINK_DIV_RST);
    end else if (wr) begin
      case (addr)
        ADDR_DATA:       data_r   <= wr_data;
        ADDR_DP:         dp_r     <= wr_data[7:0];
        ADDR_BLANK:      blank_r  <= wr_data[7:0];
        ADDR_BLINK_MASK: mask_r   <= wr_data[7:0];
        ADDR_MODE:       mode_r   <= wr_data[2:0];
        ADDR_RAW_LO:     raw_lo_r <= wr_data;
        ADDR_RAW_HI:     raw_hi_r <= wr_data;
        default:         div_r    <= wr_data[15:0];
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_DATA:       rd_mux = data_r;
      ADDR_DP:         rd_mux[7:0] = dp_r;
      ADDR_BLANK:      rd_mux[7:0] = blank_r;
      ADDR_BLINK_MASK: rd_mux[7:0] = mask_r;
      ADDR_MODE:       rd_mux = {phase, 28'd0, mode_r};
      ADDR_RAW_LO:     rd_mux = raw_lo_r;
      ADDR_RAW_HI:     rd_mux = raw_hi_r;
      default:         rd_mux[15:0] = div_r;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rd_data <= '0;
    else if (rd) rd_data <= rd_mux;
  end

  sseg_blink_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .div   (div_r),
    .phase (phase)
  );

  assign raw_all = {raw_hi_r, raw_lo_r};

  for (genvar i = 0; i < 8; i++) begin : g_digit
    logic [7:0] code;
    logic       suppressed;
    assign suppressed = (i != 0) && ((data_r >> (4 * i)) == 32'd0);
    always_comb begin
      code = hex_to_seg(data_r[4*i +: 4]) & {~dp_r[i], 7'h7F};
      if (blank_r[i])                                    code = SEG_BLANK;
      else if (mode_r[MODE_BLINK_EN] && phase && mask_r[i]) code = SEG_BLANK;
      else if (mode_r[MODE_RAW])                         code = raw_all[8*i +: 8];
      else if (mode_r[MODE_LZS] && suppressed)           code = SEG_BLANK;
    end
    assign next_seg[i] = code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) seg_q <= {8{SEG_BLANK}};
    else     seg_q <= next_seg;
  end

  assign seg0 = seg_q[0];
  assign seg1 = seg_q[1];
  assign seg2 = seg_q[2];
  assign seg3 = seg_q[3];
  assign seg4 = seg_q[4];
  assign seg5 = seg_q[5];
  assign seg6 = seg_q[6];
  assign seg7 = seg_q[7];

endmodule

// File: tb/tb_sseg_ctrl.sv
// Bench for sseg_ctrl: directed scenarios plus random bus traffic, checked
// against a register-level model with an elapsed-cycle blink phase.
module tb_sseg_ctrl;

  localparam int TICK_DIV = 4;
  localparam int BLINK_DIV_RST = 499;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic        rd;
  logic [2:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [7:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
  logic [63:0] segs;

  int n_checks = 0;
  int n_fail   = 0;

  sseg_ctrl #(.TICK_DIV(TICK_DIV), .BLINK_DIV_RST(BLINK_DIV_RST)) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .seg4(seg4), .seg5(seg5), .seg6(seg6), .seg7(seg7)
  );

  always #5 clk = ~clk;

  assign segs = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

  // Reference model state
  logic [31:0] m_data, m_raw_lo, m_raw_hi;
  logic [7:0]  m_dp, m_blank, m_mask;
  logic [2:0]  m_mode;
  logic [15:0] m_div;
  longint unsigned m_k;  // edges since counters were last cleared

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_data = 0; m_dp = 0; m_blank = 0; m_mask = 0; m_mode = 0;
    m_raw_lo = 32'hFFFF_FFFF; m_raw_hi = 32'hFFFF_FFFF;
    m_div = 16'(BLINK_DIV_RST); m_k = 0;
  endtask

  function automatic bit m_phase();
    longint unsigned period = longint'(TICK_DIV) * (longint'(m_div) + 1);
    return ((m_k / period) % 2) == 1;
  endfunction

  function automatic logic [7:0] m_digit(int i);
    logic [63:0] raw = {m_raw_hi, m_raw_lo};
    int nib = int'((m_data >> (4 * i)) & 32'hF);
    if (m_blank[i]) return 8'hFF;
    if (m_mode[1] && m_phase() && m_mask[i]) return 8'hFF;
    if (m_mode[0]) return raw[8*i +: 8];
    if (m_mode[2] && i != 0 && (m_data >> (4 * i)) == 0) return 8'hFF;
    return m_dp[i] ? (hex_tab[nib] & 8'h7F) : hex_tab[nib];
  endfunction

  function automatic logic [63:0] m_segs();
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = m_digit(i);
    return v;
  endfunction

  function automatic logic [31:0] m_read(logic [2:0] a);
    case (a)
      3'd0: return m_data;
      3'd1: return {24'd0, m_dp};
      3'd2: return {24'd0, m_blank};
      3'd3: return {24'd0, m_mask};
      3'd4: return {m_phase(), 28'd0, m_mode};
      3'd5: return m_raw_lo;
      3'd6: return m_raw_hi;
      default: return {16'd0, m_div};
    endcase
  endfunction

  // One clock: drive bus, predict, advance model, compare after the edge.
  task automatic step(input bit do_wr, input bit do_rd, input logic [2:0] a, input logic [31:0] d);
    logic [63:0] exp_seg;
    logic [31:0] exp_rd;
    bit clr;
    wr = do_wr; rd = do_rd; addr = a; wr_data = d;
    exp_seg = m_segs();
    exp_rd  = m_read(a);
    clr = 0;
    if (do_wr) begin
      case (a)
        3'd0: m_data = d;
        3'd1: m_dp = d[7:0];
        3'd2: m_blank = d[7:0];
        3'd3: m_mask = d[7:0];
        3'd4: begin clr = m_mode[1] && !d[1]; m_mode = d[2:0]; end
        3'd5: m_raw_lo = d;
        3'd6: m_raw_hi = d;
        default: begin m_div = d[15:0]; clr = 1; end
      endcase
    end
    if (clr) m_k = 0;
    else     m_k++;
    @(posedge clk);
    #1;
    wr = 0; rd = 0;
    check("seg", segs, exp_seg);
    if (do_rd) check($sformatf("rd%0d", a), {32'd0, rd_data}, {32'd0, exp_rd});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 3'd0, 32'd0);
  endtask

  initial begin
    logic [2:0]  ra;
    logic [31:0] rdat;
    int guard;
    rst = 1; wr = 0; rd = 0; addr = 0; wr_data = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_seg", segs, {8{8'hFF}});
    check("rst_rd", {32'd0, rd_data}, 64'd0);
    #2 rst = 0;

    step(0, 0, 3'd0, 32'd0);
    check("first_seg", segs, {8{8'hC0}});
    for (int a = 0; a < 8; a++) step(0, 1, 3'(a), 32'd0);
    check("rst_div", {32'd0, rd_data}, 64'd499);

    step(1, 0, 3'd0, 32'h0123ABCD);
    step(0, 0, 3'd0, 32'd0);
    check("hex", segs, 64'hC0F9A4B0_8883C6A1);

    step(1, 0, 3'd4, 32'd4);
    step(1, 0, 3'd0, 32'h00000050);
    step(0, 0, 3'd0, 32'd0);
    check("lzs50", segs, 64'hFFFFFFFF_FFFF92C0);
    step(1, 0, 3'd0, 32'd0);
    step(0, 0, 3'd0, 32'd0);
    check("lzs0", segs, 64'hFFFFFFFF_FFFFFFC0);

    step(1, 0, 3'd4, 32'd0);
    step(1, 0, 3'd1, 32'h01);
    step(1, 0, 3'd2, 32'h80);
    step(1, 0, 3'd0, 32'h88888888);
    step(0, 0, 3'd0, 32'd0);
    check("dp_blank", segs, 64'hFF808080_80808000);
    step(1, 0, 3'd4, 32'd1);
    step(1, 0, 3'd5, 32'h12345678);
    step(0, 0, 3'd0, 32'd0);
    check("raw", segs, 64'hFFFFFFFF_12345678);

    // Blink: period 8 cycles per phase
    step(1, 0, 3'd2, 32'h00);
    step(1, 0, 3'd4, 32'd0);
    step(1, 0, 3'd0, 32'h0123ABCD);
    step(1, 0, 3'd3, 32'h0F);
    step(1, 0, 3'd7, 32'd1);
    step(1, 0, 3'd4, 32'd2);
    for (int i = 0; i < 40; i++) step(0, 1, 3'd4, 32'd0);

    guard = 0;
    while (!m_phase() && guard < 64) begin
      step(0, 0, 3'd0, 32'd0);
      guard++;
    end
    step(0, 1, 3'd4, 32'd0);
    check("phase_hi", {63'd0, rd_data[31]}, 64'd1);
    step(1, 0, 3'd7, 32'd1);
    step(0, 1, 3'd4, 32'd0);
    check("phase_clr", {63'd0, rd_data[31]}, 64'd0);
    for (int i = 0; i < 10; i++) step(0, 1, 3'd4, 32'd0);

    step(1, 1, 3'd0, 32'hDEADBEEF);
    check("rd_wr_old", {32'd0, rd_data}, {32'd0, 32'h0123ABCD});
    step(0, 1, 3'd0, 32'd0);
    check("rd_wr_new", {32'd0, rd_data}, {32'd0, 32'hDEADBEEF});

    for (int i = 0; i < 400; i++) begin
      ra = 3'($urandom_range(0, 7));
      rdat = $urandom;
      if (ra == 3'd7) rdat = $urandom_range(0, 3);
      if (ra == 3'd4) rdat = $urandom_range(0, 7);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rdat);
    end

    // Asynchronous reset in the middle of blinking with a write pending
    step(1, 0, 3'd3, 32'hFF);
    step(1, 0, 3'd7, 32'd0);
    step(1, 0, 3'd4, 32'd2);
    idle(7);
    wr = 1; addr = 3'd0; wr_data = 32'h55555555;
    #1 rst = 1;
    #1;
    check("async_seg", segs, {8{8'hFF}});
    check("async_rd", {32'd0, rd_data}, 64'd0);
    m_reset();
    @(posedge clk);
    wr = 0;
    #3 rst = 0;
    step(0, 0, 3'd0, 32'd0);
    check("post_rst_seg", segs, {8{8'hC0}});
    for (int a = 0; a < 8; a++) step(0, 1, 3'(a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sseg_ctrl.md
# sseg_ctrl

Memory-mapped controller for the eight-digit seven-segment display path. Holds CPU-written display registers, performs hex-to-segment decoding, leading-zero suppression, per-digit blanking, decimal points and timed blinking, and drives registered active-low segment codes into the display multiplexer's eight digit inputs. Sits between the SoC peripheral bus and the display multiplexer.

## Interface
- TICK_DIV, 100000: clock cycles per blink tick (1 ms at 100 MHz); must be ≥ 2.
- BLINK_DIV_RST, 499: reset value of BLINK_DIV register (0.5 s half-period).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr  in  1  write strobe, one cycle per write.
- rd  in  1  read strobe.
- addr  in  3  register index.
- wr_data  in  32  write data.
- rd_data  out  32  read data, registered.
- seg0..seg7  out  8 each  active-low segment code per digit; [6:0]=g..a, [7]=dp; feed digit inputs 0..7.

## Operation
- Registers (addr: name, reset):
  - 0 DATA, 0: nibble i = hex value of digit i.
  - 1 DP[7:0], 0: 1 lights dp of digit i.
  - 2 BLANK[7:0], 0: 1 forces digit i dark.
  - 3 BLINK_MASK[7:0], 0: digits blanked during blink phase 1.
  - 4 MODE[2:0], 0: bit0 RAW, bit1 BLINK_EN, bit2 LZS. Read returns blink phase in bit31.
  - 5 RAW_LO, FFFFFFFF: byte i = raw code of digit i (0-3).
  - 6 RAW_HI, FFFFFFFF: byte i = raw code of digit i+4.
  - 7 BLINK_DIV[15:0], BLINK_DIV_RST.
- Unused write bits ignored; unused read bits return 0.
- Per-digit code, highest priority first:
  - BLANK[i] → 8'hFF.
  - BLINK_EN & phase & BLINK_MASK[i] → 8'hFF.
  - RAW → raw byte (dp bit from raw byte; DP ignored).
  - LZS & digit i suppressed → 8'hFF.
  - else hex table of nibble with bit7 = ~DP[i].
- Hex table (dp off): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
- LZS: digit i suppressed iff nibbles 7..i all zero and i ≠ 0; digit 0 never suppressed.
- Blink timer: tick counter 0..TICK_DIV-1, tick on wrap. Blink counter counts ticks 0..BLINK_DIV; on wrap, phase toggles. BLINK_DIV=0 toggles every tick.
- Writing BLINK_DIV or clearing BLINK_EN clears tick counter, blink counter and phase.
- Phase runs whether or not BLINK_EN is set.

## Timing
- Write sampled at edge N; register updated at N; seg* reflect it at edge N+1 (1-cycle output register).
- Read: rd at edge N → rd_data valid after edge N, held until next rd. Simultaneous rd/wr to same addr returns pre-write value.
- Phase toggle at edge N visible on seg* after edge N+1.
- Reset: all registers to listed values, counters and phase 0, rd_data 0, seg0..seg7 = 8'hFF. First edge after release loads seg* = 8'hC0 (DATA=0, hex mode).
- Reset mid-blink or mid-write: write discarded, all state reset immediately.

## Structure
- Package sseg_pkg: register address localparams, MODE bit positions, SEG_BLANK = 8'hFF, hex-to-segment function.
- Sub-module sseg_blink_timer (clk, rst, clear, div[15:0], phase): tick prescaler plus blink counter.
- Top: register file, read mux, per-digit priority logic (generate loop), output registers.

## Test plan
- Reset, release, write DATA=32'h0123ABCD → after 1 edge seg7..seg0 = C0 F9 A4 B0 88 83 C6 A1.
- MODE=4 (LZS), DATA=32'h00000050 → seg7..seg2 = FF, seg1 = 92, seg0 = C0; DATA=0 → only seg0 = C0.
- DP=8'h01, BLANK=8'h80, DATA=32'h88888888 → seg0 = 00, seg7 = FF, others 80; RAW=1, RAW_LO=32'h12345678 → seg0 = 78, seg3 = 12.
- TICK_DIV=4, BLINK_DIV=1, MODE=2, BLINK_MASK=8'h0F → digits 0-3 toggle FF/code every 8 cycles, digits 4-7 steady; MODE read bit31 tracks phase.
- Write BLINK_DIV while phase=1 → phase reads 0 next cycle, next toggle after full period; rd+wr same addr returns old value.
- Assert rst mid-blink with BLINK_EN → seg* = FF immediately (asynchronous), all registers at reset values after release.
